fetch_unit: RTL and testbench

//  IF-stage PC generator and fetch buffer. Sits directly upstream of imem:

---
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   IF-stage PC generator and 2-entry fetch buffer.
//
//   The unit drives the word address of a synchronous instruction memory with a
//   one-cycle read latency. It collects the returned words together with their
//   byte PC in a small FIFO and hands them to ID over a valid/ready handshake.
//   A redirect flushes everything in flight and restarts fetch at a new target
//   in the same cycle.
//
// Ports
//   clk            in   1           clock, all state updates on posedge
//   rst_n          in   1           asynchronous active-low reset
//   imem_addr      out  ADDR_WIDTH  word address to imem (combinational from fa)
//   imem_dout      in   DATA_WIDTH  imem read data for the address sampled last edge
//   redirect_valid in   1           1-cycle pulse: restart fetch at redirect_pc
//   redirect_pc    in   32          redirect byte address (bits [1:0] ignored)
//   id_valid       out  1           id_instr/id_pc hold a valid fetch word
//   id_ready       in   1           ID accepts the word this cycle
//   id_instr       out  DATA_WIDTH  fetched word at the buffer head
//   id_pc          out  32          word-aligned byte address of id_instr
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [31:0]           id_pc
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // Architectural state
  logic [31:0]           pc_q,       pc_d;
  logic                  req_vld_q,  req_vld_d;
  logic [31:0]           req_pc_q,   req_pc_d;
  logic                  head_q,     head_d;
  logic [1:0]            count_q,    count_d;
  logic                  id_valid_q, id_valid_d;
  logic [DATA_WIDTH-1:0] instr_q [2];
  logic [31:0]           epc_q   [2];

  // Combinational helpers
  logic [31:0] fa_s;
  logic        pop_s;
  logic        push_s;
  logic        issue_s;
  logic        tail_s;
  logic [2:0]  occ_s;

  // Fetch address selection and the issue / push / pop decisions.
  always_comb begin
    fa_s    = pc_q;
    pop_s   = 1'b0;
    push_s  = 1'b0;
    issue_s = 1'b0;
    tail_s  = 1'b0;
    occ_s   = 3'd0;

    if (redirect_valid) begin
      fa_s = redirect_pc & WORD_MASK;
    end else begin
      fa_s = pc_q;
    end

    pop_s  = id_valid_q & id_ready;
    // Data of a fetch issued last cycle is on imem_dout now; a redirect drops it.
    push_s = req_vld_q & ~redirect_valid;
    // Slot after the last valid entry; with count=2 this aliases the head,
    // which is only written when the head is popped in the same cycle.
    tail_s = head_q ^ count_q[0];

    // Entries that will be occupied once the in-flight word lands, after this
    // cycle's pop. Issuing only when this is <= 1 keeps the 2-entry FIFO from
    // ever overflowing, since an issued word lands two edges later at most.
    occ_s   = {1'b0, count_q} + {2'b00, req_vld_q} - {2'b00, pop_s};
    issue_s = redirect_valid | (occ_s <= 3'd1);
  end

  assign imem_addr = fa_s[ADDR_WIDTH+1:2];

  // Next-state computation for PC, request tracking and FIFO bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    req_vld_d  = 1'b0;
    req_pc_d   = req_pc_q;
    head_d     = head_q;
    count_d    = count_q;
    id_valid_d = 1'b0;

    if (issue_s) begin
      req_vld_d = 1'b1;
      req_pc_d  = fa_s;
      pc_d      = fa_s + 32'd4;
    end else begin
      req_vld_d = 1'b0;
      req_pc_d  = req_pc_q;
      pc_d      = pc_q;
    end

    if (redirect_valid) begin
      // Flush: a pop in this cycle is still taken by ID, so nothing is re-presented.
      count_d = 2'd0;
      head_d  = head_q;
    end else begin
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
      head_d  = head_q ^ pop_s;
    end

    id_valid_d = (count_d != 2'd0);
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      req_vld_q  <= 1'b0;
      req_pc_q   <= 32'h0000_0000;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      id_valid_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= 32'h0000_0000;
      end
    end else begin
      pc_q       <= pc_d;
      req_vld_q  <= req_vld_d;
      req_pc_q   <= req_pc_d;
      head_q     <= head_d;
      count_q    <= count_d;
      id_valid_q <= id_valid_d;
      for (int i = 0; i < 2; i++) begin
        if (push_s && (tail_s == 1'(i))) begin
          instr_q[i] <= imem_dout;
          epc_q[i]   <= req_pc_q;
        end else begin
          instr_q[i] <= instr_q[i];
          epc_q[i]   <= epc_q[i];
        end
      end
    end
  end

  assign id_valid = id_valid_q;
  assign id_instr = instr_q[head_q];
  assign id_pc    = epc_q[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. Two instances share the clock: one with the
//   default RESET_PC of 0, one with RESET_PC=32'h7FC to exercise the imem
//   address wrap. Each has a 1-cycle synchronous imem where word k holds
//   32'hA000_0000 + k. Inputs change and outputs are sampled on the negedge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RESET_PC = 0
  logic        rst_n;
  logic [8:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  // Instance B: RESET_PC = 0x7FC
  logic        b_rst_n;
  logic [8:0]  b_imem_addr;
  logic [31:0] b_imem_dout;
  logic        b_redirect_valid;
  logic [31:0] b_redirect_pc;
  logic        b_id_valid;
  logic        b_id_ready;
  logic [31:0] b_id_instr;
  logic [31:0] b_id_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  fetch_unit #(
    .ADDR_WIDTH (9),
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_07FC)
  ) u_dut_wrap (
    .clk            (clk),
    .rst_n          (b_rst_n),
    .imem_addr      (b_imem_addr),
    .imem_dout      (b_imem_dout),
    .redirect_valid (b_redirect_valid),
    .redirect_pc    (b_redirect_pc),
    .id_valid       (b_id_valid),
    .id_ready       (b_id_ready),
    .id_instr       (b_id_instr),
    .id_pc          (b_id_pc)
  );

  // Synchronous imem models: word k = A000_0000 + k, one cycle latency.
  always @(posedge clk) begin
    imem_dout   <= 32'hA000_0000 + {23'd0, imem_addr};
    b_imem_dout <= 32'hA000_0000 + {23'd0, b_imem_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0000_0000;
    id_ready         = 1'b1;
    b_rst_n          = 1'b0;
    b_redirect_valid = 1'b0;
    b_redirect_pc    = 32'h0000_0000;
    b_id_ready       = 1'b1;

    step();
    step();
    // Reset state
    chk("rst_valid",    {31'd0, id_valid}, 32'd0);
    chk("rst_pc",       id_pc,             32'h0000_0000);
    chk("rst_instr",    id_instr,          32'h0000_0000);
    chk("rst_addr",     {23'd0, imem_addr},   32'd0);
    chk("rst_b_addr",   {23'd0, b_imem_addr}, 32'd511);
    chk("rst_b_valid",  {31'd0, b_id_valid},  32'd0);

    // 1: start-up and steady stream with id_ready=1
    rst_n = 1'b1;
    step();
    chk("t1_latency_valid", {31'd0, id_valid}, 32'd0);
    for (int j = 0; j < 6; j++) begin
      step();
      chk("t1_valid", {31'd0, id_valid}, 32'd1);
      chk("t1_pc",    id_pc,    32'(4 * j));
      chk("t1_instr", id_instr, 32'hA000_0000 + 32'(j));
    end

    // 2: back-pressure for 6 cycles, head frozen at pc 0x14
    id_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("t2_stall_valid", {31'd0, id_valid}, 32'd1);
      chk("t2_stall_pc",    id_pc,    32'h0000_0014);
      chk("t2_stall_instr", id_instr, 32'hA000_0005);
    end
    id_ready = 1'b1;
    for (int j = 6; j < 10; j++) begin
      step();
      chk("t2_resume_valid", {31'd0, id_valid}, 32'd1);
      chk("t2_resume_pc",    id_pc,    32'(4 * j));
      chk("t2_resume_instr", id_instr, 32'hA000_0000 + 32'(j));
    end

    // 3: fill the buffer, then redirect to 0x40
    id_ready = 1'b0;
    step();
    chk("t3_full_pc", id_pc, 32'h0000_0024);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    #1;
    chk("t3_redir_addr", {23'd0, imem_addr}, 32'd16);
    step();
    chk("t3_flush_valid", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t3_valid", {31'd0, id_valid}, 32'd1);
      chk("t3_pc",    id_pc,    32'h0000_0040 + 32'(4 * j));
      chk("t3_instr", id_instr, 32'hA000_0010 + 32'(j));
    end

    // 4: misaligned redirect target, pop in the redirect cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    #1;
    chk("t4_redir_addr", {23'd0, imem_addr}, 32'd16);
    step();
    chk("t4_flush_valid", {31'd0, id_valid}, 32'd0);
    redirect_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      step();
      chk("t4_valid", {31'd0, id_valid}, 32'd1);
      chk("t4_pc",    id_pc,    32'h0000_0040 + 32'(4 * j));
      chk("t4_instr", id_instr, 32'hA000_0010 + 32'(j));
    end

    // 6: toggle id_ready, then reset mid-stream
    id_ready = 1'b0;
    step();
    chk("t6_hold_pc", id_pc, 32'h0000_0044);
    id_ready = 1'b1;
    step();
    chk("t6_pop_pc",    id_pc,    32'h0000_0048);
    chk("t6_pop_instr", id_instr, 32'hA000_0012);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_rst_pc",    id_pc,    32'h0000_0000);
    chk("t6_rst_instr", id_instr, 32'h0000_0000);
    chk("t6_rst_addr",  {23'd0, imem_addr}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_latency_valid", {31'd0, id_valid}, 32'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t6_valid", {31'd0, id_valid}, 32'd1);
      chk("t6_pc",    id_pc,    32'(4 * j));
      chk("t6_instr", id_instr, 32'hA000_0000 + 32'(j));
    end

    // 5: RESET_PC=0x7FC, imem address wraps 511 -> 0
    chk("t5_addr_511", {23'd0, b_imem_addr}, 32'd511);
    b_rst_n = 1'b1;
    step();
    chk("t5_latency_valid", {31'd0, b_id_valid}, 32'd0);
    chk("t5_addr_wrap",     {23'd0, b_imem_addr}, 32'd0);
    step();
    chk("t5_valid0", {31'd0, b_id_valid}, 32'd1);
    chk("t5_pc0",    b_id_pc,    32'h0000_07FC);
    chk("t5_instr0", b_id_instr, 32'hA000_01FF);
    step();
    chk("t5_valid1", {31'd0, b_id_valid}, 32'd1);
    chk("t5_pc1",    b_id_pc,    32'h0000_0800);
    chk("t5_instr1", b_id_instr, 32'hA000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
